// File: rtl/sbox_bram_arbiter.sv
// Round-robin arbiter sharing one dual-port read-only S-box BRAM among NUM_REQ lookup requesters.
// Grants up to two lookups per cycle and returns tagged data on two registered response lanes.
module sbox_bram_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*10-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [9:0]            bram_addra,
  output logic [9:0]            bram_addrb,
  output logic                  bram_en,
  output logic                  bram_rst,
  input  logic [7:0]            bram_doa,
  input  logic [7:0]            bram_dob,
  output logic                  resp_a_valid,
  output logic                  resp_b_valid,
  output logic [ID_W-1:0]       resp_a_id,
  output logic [ID_W-1:0]       resp_b_id,
  output logic [7:0]            resp_a_data,
  output logic [7:0]            resp_b_data
);

  localparam int LAST = READ_LAT - 1;

  logic [ID_W-1:0] rr_ptr_r;
  logic [ID_W-1:0] rr_ptr_nxt_s;
  logic            gnt_a_s;
  logic            gnt_b_s;
  logic [ID_W-1:0] idx_a_s;
  logic [ID_W-1:0] idx_b_s;

  logic [READ_LAT-1:0] tag_va_r;
  logic [READ_LAT-1:0] tag_vb_r;
  logic [ID_W-1:0]     tag_ida_r [READ_LAT];
  logic [ID_W-1:0]     tag_idb_r [READ_LAT];

  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % NUM_REQ;
  endfunction

  // Round-robin scan from rr_ptr: first requester found goes to port A, second to port B.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    idx_a_s = '0;
    idx_b_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rst && req_valid[wrap_idx(int'(rr_ptr_r), k)]) begin
        if (!gnt_a_s) begin
          gnt_a_s = 1'b1;
          idx_a_s = ID_W'(wrap_idx(int'(rr_ptr_r), k));
        end else if (!gnt_b_s) begin
          gnt_b_s = 1'b1;
          idx_b_s = ID_W'(wrap_idx(int'(rr_ptr_r), k));
        end else begin
          gnt_b_s = gnt_b_s;
        end
      end else begin
        gnt_a_s = gnt_a_s;
      end
    end
  end

  // Pointer moves just past the last requester granted this cycle.
  always_comb begin
    rr_ptr_nxt_s = rr_ptr_r;
    if (gnt_b_s) begin
      rr_ptr_nxt_s = ID_W'(wrap_idx(int'(idx_b_s), 1));
    end else if (gnt_a_s) begin
      rr_ptr_nxt_s = ID_W'(wrap_idx(int'(idx_a_s), 1));
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Ready strobes and BRAM addresses for the granted requesters; unused port parks at 0.
  always_comb begin
    req_ready  = '0;
    bram_addra = 10'd0;
    bram_addrb = 10'd0;
    if (gnt_a_s) begin
      req_ready[idx_a_s] = 1'b1;
      bram_addra         = req_addr[10*int'(idx_a_s) +: 10];
    end else begin
      bram_addra = 10'd0;
    end
    if (gnt_b_s) begin
      req_ready[idx_b_s] = 1'b1;
      bram_addrb         = req_addr[10*int'(idx_b_s) +: 10];
    end else begin
      bram_addrb = 10'd0;
    end
  end

  // Both BRAM stages stay enabled while any read is still travelling through them.
  assign bram_en  = !rst && (gnt_a_s || (|tag_va_r) || (|tag_vb_r));
  assign bram_rst = rst;

  // Arbitration pointer and tag pipeline that mirrors the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
      tag_va_r <= '0;
      tag_vb_r <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        tag_ida_r[i] <= '0;
        tag_idb_r[i] <= '0;
      end
    end else begin
      rr_ptr_r     <= rr_ptr_nxt_s;
      tag_va_r[0]  <= gnt_a_s;
      tag_vb_r[0]  <= gnt_b_s;
      tag_ida_r[0] <= idx_a_s;
      tag_idb_r[0] <= idx_b_s;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_va_r[i]  <= tag_va_r[i-1];
        tag_vb_r[i]  <= tag_vb_r[i-1];
        tag_ida_r[i] <= tag_ida_r[i-1];
        tag_idb_r[i] <= tag_idb_r[i-1];
      end
    end
  end

  // Response lanes capture BRAM data when the matching tag reaches the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_a_valid <= 1'b0;
      resp_b_valid <= 1'b0;
      resp_a_id    <= '0;
      resp_b_id    <= '0;
      resp_a_data  <= 8'd0;
      resp_b_data  <= 8'd0;
    end else begin
      resp_a_valid <= tag_va_r[LAST];
      resp_b_valid <= tag_vb_r[LAST];
      if (tag_va_r[LAST]) begin
        resp_a_id   <= tag_ida_r[LAST];
        resp_a_data <= bram_doa;
      end
      if (tag_vb_r[LAST]) begin
        resp_b_id   <= tag_idb_r[LAST];
        resp_b_data <= bram_dob;
      end
    end
  end

endmodule

// File: tb/tb_sbox_bram_arbiter.sv
// Bench for sbox_bram_arbiter: directed scenarios plus random traffic checked against
// a cycle-indexed scoreboard built from the grant/latency rules and a ROM model.
module tb_sbox_bram_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int RL   = 2;
  localparam int MAXC = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [9:0]     ra [N];
  logic [N*10-1:0] req_addr;
  logic [N-1:0]   req_ready;
  logic [9:0]     bram_addra, bram_addrb;
  logic           bram_en, bram_rst;
  logic [7:0]     bram_doa = 8'd0, bram_dob = 8'd0;
  logic           resp_a_valid, resp_b_valid;
  logic [IDW-1:0] resp_a_id, resp_b_id;
  logic [7:0]     resp_a_data, resp_b_data;

  assign req_addr = {ra[3], ra[2], ra[1], ra[0]};

  sbox_bram_arbiter #(.NUM_REQ(N), .ID_W(IDW), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .bram_addra(bram_addra), .bram_addrb(bram_addrb), .bram_en(bram_en), .bram_rst(bram_rst),
    .bram_doa(bram_doa), .bram_dob(bram_dob),
    .resp_a_valid(resp_a_valid), .resp_b_valid(resp_b_valid),
    .resp_a_id(resp_a_id), .resp_b_id(resp_b_id),
    .resp_a_data(resp_a_data), .resp_b_data(resp_b_data));

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [9:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Two-stage registered BRAM: address register then output register.
  logic [7:0] r1a = 8'd0, r1b = 8'd0;
  always @(posedge clk) begin
    if (bram_rst) begin
      r1a <= 8'd0; r1b <= 8'd0; bram_doa <= 8'd0; bram_dob <= 8'd0;
    end else if (bram_en) begin
      r1a <= rom(bram_addra); r1b <= rom(bram_addrb);
      bram_doa <= r1a; bram_dob <= r1b;
    end
  end

  int nvec = 0, nmis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard indexed by cycle number.
  bit         ev_a [MAXC], ev_b [MAXC], pend [MAXC];
  int         eid_a [MAXC], eid_b [MAXC];
  logic [7:0] edat_a [MAXC], edat_b [MAXC];
  int         lid_a = 0, lid_b = 0;
  logic [7:0] ld_a = 8'd0, ld_b = 8'd0;
  int         mptr = 0, cyc = 0;
  bit         autoclr = 1'b1;
  logic [N-1:0] gmask;

  task automatic model_cycle();
    int q[$];
    int ga, gb, last;
    logic [N-1:0] emask;
    logic [9:0] ea, eb;
    for (int k = 0; k < N; k++)
      if (!rst && req_valid[(mptr + k) % N]) q.push_back((mptr + k) % N);
    ga = (q.size() > 0) ? q[0] : -1;
    gb = (q.size() > 1) ? q[1] : -1;
    emask = '0; ea = 10'd0; eb = 10'd0;
    if (ga >= 0) begin emask[ga] = 1'b1; ea = ra[ga]; end
    if (gb >= 0) begin emask[gb] = 1'b1; eb = ra[gb]; end
    check_eq("req_ready", req_ready, emask);
    check_eq("bram_addra", bram_addra, ea);
    check_eq("bram_addrb", bram_addrb, eb);
    check_eq("bram_en", bram_en, !rst && (ga >= 0 || pend[cyc]));
    if (ev_a[cyc]) begin lid_a = eid_a[cyc]; ld_a = edat_a[cyc]; end
    if (ev_b[cyc]) begin lid_b = eid_b[cyc]; ld_b = edat_b[cyc]; end
    check_eq("resp_a_valid", resp_a_valid, ev_a[cyc]);
    check_eq("resp_a_id", resp_a_id, lid_a);
    check_eq("resp_a_data", resp_a_data, ld_a);
    check_eq("resp_b_valid", resp_b_valid, ev_b[cyc]);
    check_eq("resp_b_id", resp_b_id, lid_b);
    check_eq("resp_b_data", resp_b_data, ld_b);
    if (rst) begin
      for (int c = cyc + 1; c <= cyc + RL + 1; c++) begin
        ev_a[c] = 1'b0; ev_b[c] = 1'b0; pend[c] = 1'b0;
      end
      lid_a = 0; lid_b = 0; ld_a = 8'd0; ld_b = 8'd0; mptr = 0;
    end else if (ga >= 0) begin
      ev_a[cyc+RL+1] = 1'b1; eid_a[cyc+RL+1] = ga; edat_a[cyc+RL+1] = rom(ra[ga]);
      if (gb >= 0) begin
        ev_b[cyc+RL+1] = 1'b1; eid_b[cyc+RL+1] = gb; edat_b[cyc+RL+1] = rom(ra[gb]);
      end
      for (int c = cyc + 1; c <= cyc + RL; c++) pend[c] = 1'b1;
      last = (gb >= 0) ? gb : ga;
      mptr = (last + 1) % N;
    end
    gmask = emask;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (autoclr) req_valid = req_valid & ~gmask;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) ra[i] = 10'd0;
    @(posedge clk);
    #1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Single request from requester 1.
    ra[1] = 10'h004; req_valid = 4'b0010;
    #1;
    check_eq("single_ready", req_ready, 4'b0010);
    check_eq("single_addra", bram_addra, 10'h004);
    repeat (3) step();
    check_eq("single_resp_valid", resp_a_valid, 1'b1);
    check_eq("single_resp_id", resp_a_id, 2'd1);
    check_eq("single_resp_data", resp_a_data, 8'hA1);
    check_eq("single_no_b", resp_b_valid, 1'b0);
    step();

    // Requester 3 alone returns the pointer to 0.
    req_valid = 4'b1000;
    repeat (5) step();

    // Four simultaneous requests.
    ra[0] = 10'h010; ra[1] = 10'h021; ra[2] = 10'h132; ra[3] = 10'h243;
    req_valid = 4'b1111;
    #1;
    check_eq("quad_ready_t0", req_ready, 4'b0011);
    step();
    check_eq("quad_ready_t1", req_ready, 4'b1100);
    step();
    check_eq("quad_en_t2", bram_en, 1'b1);
    step();
    check_eq("quad_en_t3", bram_en, 1'b1);
    check_eq("quad_t3_a", {resp_a_valid, 6'd0, resp_a_id, resp_a_data}, {1'b1, 6'd0, 2'd0, 8'hB5});
    check_eq("quad_t3_b", {resp_b_valid, 6'd0, resp_b_id, resp_b_data}, {1'b1, 6'd0, 2'd1, 8'h84});
    step();
    check_eq("quad_en_t4", bram_en, 1'b0);
    check_eq("quad_t4_a", {resp_a_valid, 6'd0, resp_a_id, resp_a_data}, {1'b1, 6'd0, 2'd2, 8'h97});
    check_eq("quad_t4_b", {resp_b_valid, 6'd0, resp_b_id, resp_b_data}, {1'b1, 6'd0, 2'd3, 8'hE6});
    repeat (2) step();

    // Fairness: 0 and 3 held continuously, then 2 joins.
    autoclr = 1'b0;
    req_valid = 4'b1001;
    repeat (10) begin
      #1;
      check_eq("fair_ready", req_ready, 4'b1001);
      step();
    end
    req_valid = 4'b1101;
    found = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (req_ready[2]) found = 1'b1;
      step();
    end
    check_eq("starve_bound", found, 1'b1);
    req_valid = '0;
    autoclr = 1'b1;
    repeat (4) step();

    // Reset while two reads are in flight.
    ra[0] = 10'h055; ra[1] = 10'h066; req_valid = 4'b0011;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("rst_drop_a", resp_a_valid, 1'b0);
    check_eq("rst_drop_b", resp_b_valid, 1'b0);
    ra[2] = 10'h3FF; req_valid = 4'b0100;
    repeat (3) step();
    check_eq("post_rst_valid", resp_a_valid, 1'b1);
    check_eq("post_rst_id", resp_a_id, 2'd2);
    check_eq("post_rst_data", resp_a_data, 8'h5A);
    step();

    // Wrap-around with the pointer at 3.
    ra[3] = 10'h1AB; ra[0] = 10'h0CD; req_valid = 4'b1001;
    #1;
    check_eq("wrap_ready", req_ready, 4'b1001);
    check_eq("wrap_addra", bram_addra, 10'h1AB);
    check_eq("wrap_addrb", bram_addrb, 10'h0CD);
    step();
    ra[1] = 10'h111; req_valid = 4'b0011;
    #1;
    check_eq("wrap_next_addra", bram_addra, 10'h111);
    check_eq("wrap_next_addrb", bram_addrb, 10'h0CD);
    repeat (4) step();

    // Random traffic with occasional resets.
    autoclr = 1'b0;
    repeat (800) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) ra[i] = 10'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/sbox_bram_arbiter.md
Name: sbox_bram_arbiter

Overview:
- Shares one dual-port, read-only masked S-box BRAM among NUM_REQ lookup requesters.
- BRAM geometry: 10-bit address, 8-bit data, registered output (READ_LAT cycles address-to-data).
- Each cycle, a round-robin scheduler grants up to two requests: one on port A, one on port B.
- Drives BRAM address and enable, tracks in-flight reads with a tag pipeline, and returns data with the requester ID on two registered response lanes. Sits between the round-function share-lookup logic and the S-box BRAM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width (clog2(NUM_REQ)).
- READ_LAT, 2, BRAM address-to-data latency in cycles (1..3).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_addr  in  NUM_REQ*10  per-requester BRAM address; requester i uses slice [10*i+9:10*i].
- req_ready  out  NUM_REQ  combinational grant; a transfer happens on valid&ready.
- bram_addra  out  10  port A address.
- bram_addrb  out  10  port B address.
- bram_en  out  1  drives the BRAM port enables and output-register enables on both ports.
- bram_rst  out  1  BRAM output-register reset, equal to rst.
- bram_doa  in  8  port A read data.
- bram_dob  in  8  port B read data.
- resp_a_valid, resp_b_valid  out  1 each  response strobes.
- resp_a_id, resp_b_id  out  ID_W each  requester ID of the response.
- resp_a_data, resp_b_data  out  8 each  looked-up byte.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rr_ptr=0, all tag-pipeline valids=0, resp_*_valid=0, resp_*_id=0, resp_*_data=0, bram_en=0.
  - Reset mid-operation discards every in-flight read; no response is issued for it.
- Grant A: the first asserted req_valid scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Grant B: the next asserted req_valid after grant A in the same scan; never the same requester.
- Port use:
  - Port B is used only if port A is granted.
  - Fewer than two requests: unused port address = 0, and its tag is invalid.
  - No requests: no grants, rr_ptr unchanged.
- req_ready[i]=1 exactly when i is granted A or B; at most two ready bits per cycle; ready is 0 during rst.
- rr_ptr update: on any grant, rr_ptr <= (last granted index + 1) mod NUM_REQ, where last granted is B if B is granted, else A.
- bram_addra/bram_addrb are combinational from the granted requesters' addresses in the issue cycle T.
- Tag pipeline: depth READ_LAT per port, each stage {valid, id}, shifts every cycle unconditionally.
- bram_en = (grant this cycle) OR (any tag-pipeline stage valid). This keeps both BRAM stages enabled until the data emerges; it is low when fully idle.
- Data capture: at the end of cycle T+READ_LAT, bram_doa/dob is captured into resp_a/b_data with the matching id and valid.
- Response timing: resp_*_valid is high for exactly one cycle, at T+READ_LAT+1; total latency is 3 cycles for READ_LAT=2.
  - When a lane is invalid, its data/id hold their previous values.
- No response back-pressure: consumers must accept every response.
- Throughput: 2 lookups per cycle sustained. Back-to-back grants pipeline with no bubbles.
- Ordering: responses on each lane return in issue order. A and B issued in the same cycle return in the same cycle.
- Starvation bound: a continuously requesting requester is granted within ceil(NUM_REQ/2) cycles.

Test Plan:
- Bench ROM model: mem[a] = a[7:0] ^ 8'hA5, READ_LAT=2, NUM_REQ=4.
- Reset/idle: hold rst 3 cycles, no requests -> all resp valids 0, bram_en 0, req_ready 0, rr_ptr 0.
- Single request: req 1 addr 0x004 at cycle T -> req_ready=0010 at T; bram_addra=0x004; resp_a_valid at T+3 with id 1, data 0xA1; resp_b_valid never asserted.
- Four simultaneous requests held, addrs 0x010/0x021/0x132/0x243, rr_ptr 0:
  - T: grants 0(A), 1(B).
  - T+1: grants 2(A), 3(B).
  - Responses at T+3: {0,0xB5},{1,0x84}; at T+4: {2,0x97},{3,0xE6}.
  - bram_en high T..T+3 and low at T+4.
- Fairness: requesters 0 and 3 held continuously for 10 cycles -> both granted every cycle, 20 responses, no ID missing.
  - Then requester 2 alone joins with 0 and 3 held -> 2 granted within 2 cycles.
- Reset mid-operation: issue two grants at T, assert rst at T+1 -> no resp_*_valid at T+3; after rst release, a new request returns correct data at issue+3.
- Wrap-around: rr_ptr=3, requests on 3 and 0 -> 3 on A, 0 on B; next rr_ptr=1.
